id_operand_stage: RTL and testbench

- Parametrised successor to the decode-stage operand logic.
- Sits between the instruction decoder and EX.
- Resolves both source operands through N prioritised forwarding sources, detects load-use hazards, and resolves conditional-move write enables using forwarded data.
- Registers the result into an ID/EX pipeline register with stall, bubble and flush control.

---
 rtl/id_operand_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_id_operand_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// id_operand_stage
// Decode-side operand stage sitting between the instruction decoder and EX.
//   * Resolves both source operands through NUM_FWD prioritised forwarding
//     sources (index 0 = youngest, EX).
//   * Requests a stall when an operand's winning forwarding source is a load.
//   * Resolves movn/movz write enables from the resolved second operand.
//   * Registers everything into the ID/EX pipeline register, with flush,
//     stall and bubble control.
// Optional feature: define ID_PERF_CNT_EN to add two saturating 32-bit
// performance counters (stall_cnt_o, issue_cnt_o).

module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int AOP_W   = 8,
  parameter int ASEL_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,

  // Decoder side
  input  logic                        id_valid_i,
  input  logic                        reg1_read_i,
  input  logic                        reg2_read_i,
  input  logic [ADDR_W-1:0]           reg1_addr_i,
  input  logic [ADDR_W-1:0]           reg2_addr_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [AOP_W-1:0]            aluop_i,
  input  logic [ASEL_W-1:0]           alusel_i,
  input  logic [ADDR_W-1:0]           wd_i,
  input  logic                        wreg_i,
  input  logic [1:0]                  cond_mov_i,

  // Register file read data
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,

  // Forwarding sources, slice i belongs to source i
  input  logic [NUM_FWD-1:0]          fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic [NUM_FWD-1:0]          fwd_load_i,

  // Pipeline control
  input  logic                        stall_i,
  input  logic                        flush_i,

  // Combinational outputs
  output logic [ADDR_W-1:0]           reg1_addr_o,
  output logic [ADDR_W-1:0]           reg2_addr_o,
  output logic                        stallreq_o,

  // ID/EX pipeline register
  output logic                        ex_valid_o,
  output logic [AOP_W-1:0]            ex_aluop_o,
  output logic [ASEL_W-1:0]           ex_alusel_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [ADDR_W-1:0]           ex_wd_o,
  output logic                        ex_wreg_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 issue_cnt_o
`endif
);

  // Conditional-move encodings of cond_mov_i
  typedef enum logic [1:0] {
    CMOV_NONE = 2'b00,
    CMOV_MOVN = 2'b01,
    CMOV_MOVZ = 2'b10,
    CMOV_RSVD = 2'b11
  } cmov_e;

  // A resolved operand: its value, and whether it came from a load whose
  // data is not available yet.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              load;
  } operand_t;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic              valid;
    logic [AOP_W-1:0]  aluop;
    logic [ASEL_W-1:0] alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
  } ex_t;

  localparam ex_t EX_BUBBLE = '0;

  // Resolve one operand. The scan runs from the oldest source down to the
  // youngest so that the last assignment, i.e. the youngest match, wins.
  // Register 0 is hard-wired to zero and is never forwarded nor stalled on.
  function automatic operand_t resolve_operand(
    input logic                      rd,
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [DATA_W-1:0]         imm,
    input logic [NUM_FWD-1:0]        f_wreg,
    input logic [NUM_FWD*ADDR_W-1:0] f_wd,
    input logic [NUM_FWD*DATA_W-1:0] f_wdata,
    input logic [NUM_FWD-1:0]        f_load
  );
    operand_t res;
    res.data = imm;
    res.load = 1'b0;
    if (rd) begin
      if (addr == '0) begin
        res.data = '0;
      end else begin
        res.data = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
          if (f_wreg[i] && (f_wd[i*ADDR_W +: ADDR_W] == addr)) begin
            res.data = f_wdata[i*DATA_W +: DATA_W];
            res.load = f_load[i];
          end
        end
      end
    end
    return res;
  endfunction

  operand_t op1;
  operand_t op2;
  logic     load_use;
  logic     wreg_res;
  logic     capture_en;
  ex_t      ex_q;
  ex_t      ex_next;

  // Regfile addresses go straight out so the read happens this cycle
  assign reg1_addr_o = reg1_addr_i;
  assign reg2_addr_o = reg2_addr_i;

  // Operand resolution through the forwarding network
  always_comb begin
    op1 = resolve_operand(reg1_read_i, reg1_addr_i, reg1_data_i, imm_i,
                          fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_load_i);
    op2 = resolve_operand(reg2_read_i, reg2_addr_i, reg2_data_i, imm_i,
                          fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_load_i);
  end

  // A valid instruction whose winning source is a pending load must wait;
  // this is independent of stall_i so upstream keeps holding ID.
  assign load_use   = id_valid_i && (op1.load || op2.load);
  assign stallreq_o = load_use;

  // Conditional-move write enable, decided on the resolved second operand
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wreg_res = wreg_i;
    case (cmov_e'(cond_mov_i))
      CMOV_NONE: wreg_res = wreg_i;
      CMOV_MOVN: wreg_res = wreg_i && (op2.data != '0);
      CMOV_MOVZ: wreg_res = wreg_i && (op2.data == '0);
      CMOV_RSVD: wreg_res = 1'b0;
      default:   wreg_res = 1'b0;
    endcase
  end

  // An instruction is issued into EX only when nothing blocks it
  assign capture_en = !flush_i && !stall_i && !load_use && id_valid_i;

  // Next pipeline-register value: flush > stall > load-use > invalid > capture
  always_comb begin
    ex_next = ex_q;
    if (flush_i) begin
      ex_next = EX_BUBBLE;
    end else if (stall_i) begin
      ex_next = ex_q;
    end else if (load_use || !id_valid_i) begin
      ex_next = EX_BUBBLE;
    end else begin
      ex_next.valid  = 1'b1;
      ex_next.aluop  = aluop_i;
      ex_next.alusel = alusel_i;
      ex_next.reg1   = op1.data;
      ex_next.reg2   = op2.data;
      ex_next.wd     = wd_i;
      ex_next.wreg   = wreg_res;
    end
  end

  // ID/EX pipeline register, cleared to a bubble by reset
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_next;
    end
  end

  assign ex_valid_o  = ex_q.valid;
  assign ex_aluop_o  = ex_q.aluop;
  assign ex_alusel_o = ex_q.alusel;
  assign ex_reg1_o   = ex_q.reg1;
  assign ex_reg2_o   = ex_q.reg2;
  assign ex_wd_o     = ex_q.wd;
  assign ex_wreg_o   = ex_q.wreg;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] issue_cnt_q;

  // Saturating counters of load-use stall cycles and issued instructions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (load_use && !flush_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (capture_en && (issue_cnt_q != '1)) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign issue_cnt_o = issue_cnt_q;
`else
  // Without the counters the issue condition has no consumer
  logic unused_capture_en;
  assign unused_capture_en = capture_en;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage
// Directed bench for id_operand_stage with the default parameters. Expected
// ID/EX register contents are queued when an instruction is driven and
// popped when the register is sampled one cycle later. Counter checks are
// active when ID_PERF_CNT_EN is defined.

module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid_i;
  logic        reg1_read_i, reg2_read_i;
  logic [4:0]  reg1_addr_i, reg2_addr_i;
  logic [31:0] imm_i;
  logic [7:0]  aluop_i = 8'h00;
  logic [2:0]  alusel_i = 3'd0;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [1:0]  cond_mov_i;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_load_i;
  logic        stall_i, flush_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        stallreq_o;
  logic        ex_valid_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_o, issue_cnt_o;
`endif

  id_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid_i  (id_valid_i),
    .reg1_read_i (reg1_read_i),
    .reg2_read_i (reg2_read_i),
    .reg1_addr_i (reg1_addr_i),
    .reg2_addr_i (reg2_addr_i),
    .imm_i       (imm_i),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .cond_mov_i  (cond_mov_i),
    .reg1_data_i (reg1_data_i),
    .reg2_data_i (reg2_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_load_i  (fwd_load_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .reg1_addr_o (reg1_addr_o),
    .reg2_addr_o (reg2_addr_o),
    .stallreq_o  (stallreq_o),
    .ex_valid_o  (ex_valid_o),
    .ex_aluop_o  (ex_aluop_o),
    .ex_alusel_o (ex_alusel_o),
    .ex_reg1_o   (ex_reg1_o),
    .ex_reg2_o   (ex_reg2_o),
    .ex_wd_o     (ex_wd_o),
    .ex_wreg_o   (ex_wreg_o)
`ifdef ID_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .issue_cnt_o (issue_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare the whole ID/EX register
  task automatic check_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"},  32'(ex_valid_o),  32'(e.valid));
      chk({tag, ".aluop"},  32'(ex_aluop_o),  32'(e.aluop));
      chk({tag, ".alusel"}, 32'(ex_alusel_o), 32'(e.alusel));
      chk({tag, ".reg1"},   ex_reg1_o,        e.r1);
      chk({tag, ".reg2"},   ex_reg2_o,        e.r2);
      chk({tag, ".wd"},     32'(ex_wd_o),     32'(e.wd));
      chk({tag, ".wreg"},   32'(ex_wreg_o),   32'(e.wreg));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic push_exp(input logic [31:0] r1, input logic [31:0] r2, input logic wreg);
    exp_t e;
    e = '{1'b1, aluop_i, alusel_i, r1, r2, wd_i, wreg};
    sb.push_back(e);
    last_exp = e;
  endtask

  task automatic push_bub();
    exp_t e;
    e = '{1'b0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0};
    sb.push_back(e);
    last_exp = e;
  endtask

  task automatic push_hold();
    sb.push_back(last_exp);
  endtask

  task automatic clear();
    id_valid_i  = 1'b0;
    reg1_read_i = 1'b0;
    reg2_read_i = 1'b0;
    reg1_addr_i = 5'd0;
    reg2_addr_i = 5'd0;
    imm_i       = 32'h0;
    wd_i        = 5'd0;
    wreg_i      = 1'b0;
    cond_mov_i  = 2'b00;
    reg1_data_i = 32'h0;
    reg2_data_i = 32'h0;
    fwd_wreg_i  = 2'b00;
    fwd_wd_i    = 10'h0;
    fwd_wdata_i = 64'h0;
    fwd_load_i  = 2'b00;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Present a new valid instruction; aluop/alusel change every time so a
  // stale capture is visible.
  task automatic instr(input logic rd1, input logic [4:0] a1,
                       input logic rd2, input logic [4:0] a2,
                       input logic [31:0] imm, input logic [4:0] wd,
                       input logic wreg, input logic [1:0] cm);
    id_valid_i  = 1'b1;
    reg1_read_i = rd1;
    reg1_addr_i = a1;
    reg2_read_i = rd2;
    reg2_addr_i = a2;
    imm_i       = imm;
    wd_i        = wd;
    wreg_i      = wreg;
    cond_mov_i  = cm;
    aluop_i     = aluop_i + 8'h13;
    alusel_i    = alusel_i + 3'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear();
    // Reset state while rst is held low
    #12;
    push_bub();
    check_now("reset");
    rst = 1'b1;

    // Youngest matching source wins over an older one
    instr(1'b1, 5'd3, 1'b0, 5'd0, 32'h55, 5'd8, 1'b1, 2'b00);
    reg1_data_i = 32'hDEAD;
    fwd_wreg_i  = 2'b11;
    fwd_wd_i    = {5'd3, 5'd3};
    fwd_wdata_i = {32'h1111, 32'hAAAA0000};
    #1;
    chk("addr1_pass", 32'(reg1_addr_o), 32'd3);
    chk("youngest.stallreq", 32'(stallreq_o), 32'd0);
    push_exp(32'hAAAA0000, 32'h55, 1'b1);
    step("youngest");

    // Only the older source matches
    instr(1'b1, 5'd3, 1'b0, 5'd0, 32'h66, 5'd9, 1'b1, 2'b00);
    fwd_wreg_i = 2'b10;
    push_exp(32'h1111, 32'h66, 1'b1);
    step("older");

    // Register 0 reads zero even with a matching load source; no fwd hit on r4
    clear();
    instr(1'b1, 5'd4, 1'b1, 5'd0, 32'h0, 5'd10, 1'b1, 2'b00);
    fwd_wreg_i  = 2'b01;
    fwd_wd_i    = {5'd4, 5'd0};
    fwd_wdata_i = {32'h4444, 32'hFFFF};
    fwd_load_i  = 2'b01;
    reg1_data_i = 32'h0404;
    reg2_data_i = 32'h1234;
    #1;
    chk("r0.stallreq", 32'(stallreq_o), 32'd0);
    push_exp(32'h0404, 32'h0, 1'b1);
    step("r0");

    // Load-use on the youngest source: stall, then capture regfile data
    clear();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd11, 1'b1, 2'b00);
    fwd_wreg_i  = 2'b01;
    fwd_wd_i    = {5'd0, 5'd5};
    fwd_wdata_i = {32'h0, 32'h5555};
    fwd_load_i  = 2'b01;
    reg1_data_i = 32'hBEEF;
    #1;
    chk("loaduse.stallreq", 32'(stallreq_o), 32'd1);
    push_bub();
    step("loaduse");
    fwd_wreg_i = 2'b00;
    fwd_load_i = 2'b00;
    #1;
    chk("afterload.stallreq", 32'(stallreq_o), 32'd0);
    push_exp(32'hBEEF, 32'h0, 1'b1);
    step("afterload");

    // Older load masked by a younger non-load match
    clear();
    instr(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 2'b00);
    fwd_wreg_i  = 2'b11;
    fwd_wd_i    = {5'd5, 5'd5};
    fwd_wdata_i = {32'h9999, 32'h5050};
    fwd_load_i  = 2'b10;
    #1;
    chk("masked.stallreq", 32'(stallreq_o), 32'd0);
    push_exp(32'h5050, 32'h0, 1'b1);
    step("masked");

    // Older load that wins on operand 2 stalls; same hazard without valid does not
    clear();
    instr(1'b0, 5'd0, 1'b1, 5'd6, 32'h77, 5'd13, 1'b1, 2'b00);
    fwd_wreg_i = 2'b11;
    fwd_wd_i   = {5'd6, 5'd9};
    fwd_load_i = 2'b10;
    #1;
    chk("oldload.stallreq", 32'(stallreq_o), 32'd1);
    push_bub();
    step("oldload");
    id_valid_i = 1'b0;
    #1;
    chk("invalid.stallreq", 32'(stallreq_o), 32'd0);
    push_bub();
    step("invalid");

    // Conditional moves on forwarded operand 2
    clear();
    instr(1'b0, 5'd0, 1'b1, 5'd6, 32'h0, 5'd14, 1'b1, 2'b01);
    fwd_wreg_i  = 2'b01;
    fwd_wd_i    = {5'd0, 5'd6};
    fwd_wdata_i = {32'h0, 32'h0};
    reg2_data_i = 32'h99;
    push_exp(32'h0, 32'h0, 1'b0);
    step("movn_zero");
    fwd_wdata_i = {32'h0, 32'h7};
    push_exp(32'h0, 32'h7, 1'b1);
    step("movn_seven");
    cond_mov_i  = 2'b10;
    fwd_wdata_i = {32'h0, 32'h0};
    push_exp(32'h0, 32'h0, 1'b1);
    step("movz_zero");
    fwd_wdata_i = {32'h0, 32'h7};
    push_exp(32'h0, 32'h7, 1'b0);
    step("movz_seven");
    cond_mov_i = 2'b11;
    push_exp(32'h0, 32'h7, 1'b0);
    step("cmov_rsvd");
    cond_mov_i = 2'b01;
    wreg_i     = 1'b0;
    push_exp(32'h0, 32'h7, 1'b0);
    step("movn_nowreg");

    // Stall holds for three cycles (stallreq still visible), then flush wins
    clear();
    instr(1'b1, 5'd2, 1'b1, 5'd3, 32'h0, 5'd15, 1'b1, 2'b00);
    reg1_data_i = 32'hA1;
    reg2_data_i = 32'hB2;
    push_exp(32'hA1, 32'hB2, 1'b1);
    step("capA");
    clear();
    instr(1'b1, 5'd7, 1'b0, 5'd0, 32'h33, 5'd16, 1'b1, 2'b00);
    reg1_data_i = 32'hC3;
    stall_i     = 1'b1;
    push_hold();
    step("hold1");
    push_hold();
    step("hold2");
    fwd_wreg_i = 2'b01;
    fwd_wd_i   = {5'd0, 5'd7};
    fwd_load_i = 2'b01;
    #1;
    chk("hold3.stallreq", 32'(stallreq_o), 32'd1);
    push_hold();
    step("hold3");
    flush_i = 1'b1;
    push_bub();
    step("flush_over_stall");
    flush_i    = 1'b0;
    stall_i    = 1'b0;
    fwd_wreg_i = 2'b00;
    fwd_load_i = 2'b00;
    push_exp(32'hC3, 32'h33, 1'b1);
    step("resume");

    // Asynchronous reset right after a capture
    clear();
    instr(1'b1, 5'd1, 1'b1, 5'd2, 32'h0, 5'd17, 1'b1, 2'b00);
    reg1_data_i = 32'h11;
    reg2_data_i = 32'h22;
    push_exp(32'h11, 32'h22, 1'b1);
    step("capR");
    #2;
    rst = 1'b0;
    #1;
    push_bub();
    check_now("rst_async");
    push_bub();
    step("rst_hold");
    rst = 1'b1;

`ifdef ID_PERF_CNT_EN
    chk("stall_cnt.reset", stall_cnt_o, 32'd0);
    chk("issue_cnt.reset", issue_cnt_o, 32'd0);
`endif

    // Ten issues, four load-use stalls, plus cycles that must not count
    clear();
    reg1_data_i = 32'h11;
    for (int i = 0; i < 10; i++) begin
      instr(1'b1, 5'd1, 1'b0, 5'd0, 32'(i), 5'd1, 1'b1, 2'b00);
      push_exp(32'h11, 32'(i), 1'b1);
      step("issue");
    end
    fwd_wreg_i = 2'b01;
    fwd_wd_i   = {5'd0, 5'd1};
    fwd_load_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push_bub();
      step("stallcyc");
    end
    flush_i = 1'b1;
    push_bub();
    step("flush_stallreq");
    flush_i    = 1'b0;
    fwd_wreg_i = 2'b00;
    fwd_load_i = 2'b00;
    stall_i    = 1'b1;
    push_hold();
    step("stall_no_issue");
    stall_i = 1'b0;
    id_valid_i = 1'b0;
    push_bub();
    step("idle");

`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, 32'd4);
    chk("issue_cnt", issue_cnt_o, 32'd10);
`endif

    clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
